// File: rtl/dcache_store_buffer_pkg.sv
// Shared definitions for the D-cache store buffer: queue operation encoding
// and the byte-offset width of a data word.
package dcache_store_buffer_pkg;

  // What the queue does in a given cycle; drives the occupancy update.
  typedef enum logic [1:0] {
    SB_IDLE = 2'b00,
    SB_POP  = 2'b01,
    SB_PUSH = 2'b10,
    SB_BOTH = 2'b11
  } sb_op_e;

  // Number of byte-offset bits below the word address.
  function automatic int offset_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/dcache_sb_fwd.sv
// Store-to-load forwarding merge. Entries are visited oldest to youngest
// starting at the read index, so a younger store's bytes overwrite an older
// store's bytes in the same lane. Purely combinational.
module dcache_sb_fwd #(
  parameter int  DATA_WIDTH  = 32,
  parameter int  WADDR_WIDTH = 30,
  parameter int  DEPTH       = 4,
  localparam int MASK_WIDTH  = DATA_WIDTH / 8,
  localparam int IDX_W       = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WADDR_WIDTH-1:0] entry_waddr,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  entry_data,
  input  logic [DEPTH-1:0][MASK_WIDTH-1:0]  entry_mask,
  input  logic [DEPTH-1:0]                  occupied,
  input  logic [IDX_W-1:0]                  rd_idx,
  input  logic [WADDR_WIDTH-1:0]            ld_waddr,
  output logic [DATA_WIDTH-1:0]             fwd_data,
  output logic [MASK_WIDTH-1:0]             fwd_mask
);

  // Byte lanes each physical slot contributes (zero if empty or other word).
  logic [DEPTH-1:0][MASK_WIDTH-1:0] sel_mask;
  // Same information rotated into age order: index 0 is the oldest entry.
  logic [DEPTH-1:0][MASK_WIDTH-1:0] ord_mask;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ord_data;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign sel_mask[gi] = (occupied[gi] && (entry_waddr[gi] == ld_waddr))
                          ? entry_mask[gi] : '0;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [IDX_W-1:0] phys;
    assign phys         = rd_idx + IDX_W'(gi);
    assign ord_mask[gi] = sel_mask[phys];
    assign ord_data[gi] = entry_data[phys];
  end

  // Oldest-to-youngest merge; later (younger) matches win per lane.
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_mask = fwd_mask | ord_mask[k];
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (ord_mask[k][b]) begin
          fwd_data[b*8 +: 8] = ord_data[k][b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_store_buffer.sv
// D-cache store buffer: in-order FIFO of {addr, data, mask} between the LSU
// and the data-array write port, with combinational store-to-load forwarding.
module dcache_store_buffer
  import dcache_store_buffer_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 32,
  parameter int  DEPTH      = 4,
  localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic [MASK_WIDTH-1:0]   st_mask,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [MASK_WIDTH-1:0]   wr_mask,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic [MASK_WIDTH-1:0]   fwd_mask,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int IDX_W       = $clog2(DEPTH);
  localparam int PTR_W       = IDX_W + 1;
  localparam int OFFSET_BITS = offset_bits(DATA_WIDTH);
  localparam int WADDR_W     = ADDR_WIDTH - OFFSET_BITS;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] count_reg;
  logic [PTR_W-1:0] count_next;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             push;
  logic             pop;
  sb_op_e           op;

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_arr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_arr;
  logic [DEPTH-1:0][MASK_WIDTH-1:0] mask_arr;
  logic [DEPTH-1:0][WADDR_W-1:0]    waddr_arr;
  logic [DEPTH-1:0]                 occupied;

  // The wrap bits are kept for debug visibility; occupancy comes from count.
  logic unused_bits;
  assign unused_bits = ^{ld_addr, wr_ptr_reg[IDX_W], rd_ptr_reg[IDX_W]};

  assign wr_idx   = wr_ptr_reg[IDX_W-1:0];
  assign rd_idx   = rd_ptr_reg[IDX_W-1:0];

  // Handshakes depend on registered occupancy only, so st_ready has no
  // path from wr_ready: a full buffer refuses a store even while popping.
  assign st_ready = (count_reg != PTR_W'(DEPTH));
  assign wr_valid = (count_reg != '0);
  assign push     = st_valid && st_ready;
  assign pop      = wr_valid && wr_ready;

  assign count    = count_reg;
  assign empty    = (count_reg == '0);

  // Head entry is presented only while valid so stale slots never leak out.
  assign wr_addr  = wr_valid ? addr_arr[rd_idx] : '0;
  assign wr_data  = wr_valid ? data_arr[rd_idx] : '0;
  assign wr_mask  = wr_valid ? mask_arr[rd_idx] : '0;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [MASK_WIDTH-1:0] mask_reg;
    logic [IDX_W-1:0]      age;

    assign en = push && (wr_idx == IDX_W'(gi));

    // Capture an accepted store into this slot.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        addr_reg <= '0;
        data_reg <= '0;
        mask_reg <= '0;
      end else if (en) begin
        addr_reg <= st_addr;
        data_reg <= st_data;
        mask_reg <= st_mask;
      end
    end

    assign addr_arr[gi]  = addr_reg;
    assign data_arr[gi]  = data_reg;
    assign mask_arr[gi]  = mask_reg;
    assign waddr_arr[gi] = addr_reg[ADDR_WIDTH-1:OFFSET_BITS];

    // A slot is live when its distance from the head is below the count.
    assign age           = IDX_W'(gi) - rd_idx;
    assign occupied[gi]  = ({1'b0, age} < count_reg);
  end

  // Classify this cycle's queue activity.
  always_comb begin
    op = SB_IDLE;
    case ({push, pop})
      2'b10:   op = SB_PUSH;
      2'b01:   op = SB_POP;
      2'b11:   op = SB_BOTH;
      default: op = SB_IDLE;
    endcase
  end

  // Next occupancy from the queue activity.
  always_comb begin
    count_next = count_reg;
    case (op)
      SB_PUSH: count_next = count_reg + PTR_W'(1);
      SB_POP:  count_next = count_reg - PTR_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  dcache_sb_fwd #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WADDR_WIDTH (WADDR_W),
    .DEPTH       (DEPTH)
  ) u_fwd (
    .entry_waddr (waddr_arr),
    .entry_data  (data_arr),
    .entry_mask  (mask_arr),
    .occupied    (occupied),
    .rd_idx      (rd_idx),
    .ld_waddr    (ld_addr[ADDR_WIDTH-1:OFFSET_BITS]),
    .fwd_data    (fwd_data),
    .fwd_mask    (fwd_mask)
  );

  assign fwd_hit = |fwd_mask;

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Bench for dcache_store_buffer: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dcache_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } st_t;

  st_t q[$];

  dcache_store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_mask  (st_mask),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask),
    .ld_addr  (ld_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .fwd_mask (fwd_mask),
    .count    (count),
    .empty    (empty)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference forwarding: walk stores oldest to youngest, youngest wins.
  function automatic void model_fwd(input logic [31:0] la, output logic [31:0] d,
                                    output logic [3:0] m);
    d = '0;
    m = '0;
    foreach (q[i]) begin
      if (q[i].addr[31:2] == la[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (q[i].mask[b]) begin
            d[b*8 +: 8] = q[i].data[b*8 +: 8];
            m[b] = 1'b1;
          end
        end
      end
    end
  endfunction

  // Model of queue contents, advanced on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = st_valid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && wr_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{addr: st_addr, data: st_data, mask: st_mask});
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      logic [31:0] ed;
      logic [3:0]  em;
      model_fwd(ld_addr, ed, em);
      chk("count", 64'(count), 64'(q.size()));
      chk("empty", 64'(empty), 64'(q.size() == 0));
      chk("st_ready", 64'(st_ready), 64'(q.size() < DEPTH));
      chk("wr_valid", 64'(wr_valid), 64'(q.size() > 0));
      chk("wr_addr", 64'(wr_addr), (q.size() > 0) ? 64'(q[0].addr) : 64'd0);
      chk("wr_data", 64'(wr_data), (q.size() > 0) ? 64'(q[0].data) : 64'd0);
      chk("wr_mask", 64'(wr_mask), (q.size() > 0) ? 64'(q[0].mask) : 64'd0);
      chk("fwd_mask", 64'(fwd_mask), 64'(em));
      chk("fwd_data", 64'(fwd_data), 64'(ed));
      chk("fwd_hit", 64'(fwd_hit), 64'(em != 4'd0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mask  = m;
  endtask

  initial begin
    rst_n    = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_mask  = '0;
    wr_ready = 1'b0;
    ld_addr  = '0;
    #2;
    rst_n    = 1'b0;
    check_en = 1'b1;
    #1;
    chk("reset st_ready", 64'(st_ready), 64'd1);
    chk("reset wr_valid", 64'(wr_valid), 64'd0);
    chk("reset count", 64'(count), 64'd0);
    chk("reset empty", 64'(empty), 64'd1);
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Single store, visible on the write port the following cycle.
    wr_ready = 1'b1;
    drive_store(32'h100, 32'hAABBCCDD, 4'hF);
    cyc();
    st_valid = 1'b0;
    ld_addr  = 32'h103;
    #1;
    chk("single wr_valid", 64'(wr_valid), 64'd1);
    chk("single wr_addr", 64'(wr_addr), 64'h100);
    chk("single wr_data", 64'(wr_data), 64'hAABBCCDD);
    chk("single wr_mask", 64'(wr_mask), 64'hF);
    chk("single fwd_data", 64'(fwd_data), 64'hAABBCCDD);
    cyc();
    chk("single empty after pop", 64'(empty), 64'd1);

    // Fill while the array stalls, then hold a fifth store.
    wr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_store(32'h400 + 32'(k * 4), 32'h1000 + 32'(k), 4'hF);
      cyc();
    end
    drive_store(32'h410, 32'h1004, 4'hF);
    chk("full count", 64'(count), 64'd4);
    chk("full st_ready", 64'(st_ready), 64'd0);
    repeat (10) cyc();
    chk("stall wr_addr", 64'(wr_addr), 64'h400);
    chk("stall wr_data", 64'(wr_data), 64'h1000);
    chk("stall count", 64'(count), 64'd4);
    // Full with a pending store and a grant: pop only.
    wr_ready = 1'b1;
    cyc();
    chk("full pop count", 64'(count), 64'd3);
    chk("full pop st_ready", 64'(st_ready), 64'd1);
    chk("full pop head", 64'(wr_addr), 64'h404);
    cyc();
    chk("push after pop count", 64'(count), 64'd3);
    st_valid = 1'b0;
    repeat (4) cyc();
    chk("drain empty", 64'(empty), 64'd1);

    // Overlapping stores in one word: younger store wins lane 1.
    wr_ready = 1'b0;
    drive_store(32'h200, 32'h11111111, 4'h3);
    cyc();
    drive_store(32'h200, 32'h22222222, 4'h6);
    cyc();
    st_valid = 1'b0;
    ld_addr  = 32'h202;
    #1;
    chk("fwd merge mask", 64'(fwd_mask), 64'h7);
    chk("fwd merge data", 64'(fwd_data), 64'h00222211);
    chk("fwd merge hit", 64'(fwd_hit), 64'd1);
    ld_addr = 32'h204;
    #1;
    chk("fwd other word hit", 64'(fwd_hit), 64'd0);
    chk("fwd other word data", 64'(fwd_data), 64'd0);
    wr_ready = 1'b1;
    repeat (2) cyc();
    wr_ready = 1'b0;

    // Streaming with a toggling grant to wrap the pointers.
    for (int i = 0; i < 20; i++) begin
      drive_store(32'h300 + (((i % 3) == 0) ? 32'd4 : 32'd0),
                  32'h01010101 * 32'(i + 1), 4'((i % 15) + 1));
      wr_ready = (i % 2) == 1;
      ld_addr  = (i % 2 == 1) ? 32'h302 : 32'h304;
      cyc();
    end
    st_valid = 1'b0;
    wr_ready = 1'b1;
    repeat (6) cyc();
    chk("stream drained", 64'(empty), 64'd1);

    // Asynchronous reset with stores queued.
    wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_store(32'h500 + 32'(k * 4), 32'h5000 + 32'(k), 4'hF);
      cyc();
    end
    st_valid = 1'b0;
    chk("pre-reset count", 64'(count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset wr_valid", 64'(wr_valid), 64'd0);
    chk("async reset count", 64'(count), 64'd0);
    chk("async reset empty", 64'(empty), 64'd1);
    chk("async reset wr_addr", 64'(wr_addr), 64'd0);
    cyc();
    rst_n    = 1'b1;
    wr_ready = 1'b1;
    repeat (4) cyc();
    chk("no write after reset", 64'(wr_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_store_buffer.md
Name: dcache_store_buffer

Overview:
Write-side companion of the D-cache read-data holder. Accepts stores from the LSU on a valid/ready handshake and queues address, data and byte mask in a small FIFO. Drains them in order into the data-array write port whenever the array grants. Provides combinational store-to-load forwarding so loads see queued, not-yet-written stores.

Parameters:
DATA_WIDTH, 32, store/array data width in bits; multiple of 8, power of 2
ADDR_WIDTH, 32, byte address width
DEPTH, 4, number of entries; power of 2, >= 2
MASK_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridden)

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
st_valid  in  1  LSU store request valid
st_ready  out  1  buffer can accept a store
st_addr  in  ADDR_WIDTH  store byte address
st_data  in  DATA_WIDTH  store data, lane-aligned
st_mask  in  MASK_WIDTH  byte enables
wr_valid  out  1  head entry presented to the data array
wr_ready  in  1  data array accepts the write this cycle
wr_addr  out  ADDR_WIDTH  head address
wr_data  out  DATA_WIDTH  head data
wr_mask  out  MASK_WIDTH  head byte mask
ld_addr  in  ADDR_WIDTH  load address to check for forwarding
fwd_hit  out  1  at least one byte forwarded
fwd_data  out  DATA_WIDTH  merged forwarded bytes; 0 in unforwarded lanes
fwd_mask  out  MASK_WIDTH  bytes supplied by fwd_data
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count == 0

Behaviour:
- Storage: DEPTH entries {addr, data, mask}. wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits with a wrap bit. count is a register.
- Reset (async, reset=0): pointers=0, count=0, all entry fields=0.
  - Outputs during/after reset: st_ready=1, wr_valid=0, wr_addr/wr_data/wr_mask=0, fwd_hit=0, fwd_data=0, fwd_mask=0, count=0, empty=1.
  - Reset mid-operation discards all queued stores. No partial write is issued after reset deasserts.
- Push:
  - Occurs when st_valid & st_ready. Entry is written at wr_ptr and wr_ptr increments (wraps naturally).
  - st_ready = (count != DEPTH), from registered state only. No combinational path from wr_ready.
  - Full plus simultaneous pop: push is NOT accepted that cycle.
- Pop:
  - wr_valid = (count != 0). wr_* is driven from the entry at rd_ptr.
  - Pop occurs when wr_valid & wr_ready; rd_ptr increments.
  - While wr_valid & ~wr_ready, wr_addr/wr_data/wr_mask stay stable. wr_valid never deasserts without a pop.
- count update: push only +1; pop only -1; both or neither unchanged. empty = (count==0).
- Latency: a store accepted in cycle N into an empty buffer appears on wr_* in cycle N+1. No same-cycle bypass.
- Ordering: strict FIFO; writes leave in acceptance order.
- Forwarding (combinational):
  - Compare word address: addr[ADDR_WIDTH-1:$clog2(MASK_WIDTH)] of each occupied entry against ld_addr.
  - For each byte lane, take the youngest matching entry whose mask bit is set.
  - fwd_mask = OR of matching masks. fwd_hit = |fwd_mask. fwd_data lanes not in fwd_mask = 0.
  - The entry being pushed this cycle is not visible. The entry being popped this cycle is still visible.
- Wrap-around: after 2*DEPTH pushes/pops, ordering and forwarding age must remain correct. Age is computed relative to rd_ptr, not by physical index.

Decomposition:
- Shared dcache defines header: OFFSET_BITS = $clog2(DATA_WIDTH/8) and the word-address slice macro. Shared with the read-side holder and tag logic.
- Entry registers use the existing dff_aren cells (en = push & index match).
- One natural sub-module: dcache_sb_fwd. Purely combinational age-ordered byte merge: inputs are entry arrays, occupancy vector, rd_ptr and ld_addr; outputs are fwd_data/fwd_mask.

Test Plan:
- Reset then single store {addr 0x100, data 0xAABBCCDD, mask 0xF}, wr_ready=1 -> wr_valid rises next cycle with those values. Pop that cycle; empty=1 after.
- wr_ready=0, push 4 stores -> count=4, st_ready=0. 5th st_valid held, not accepted. wr_* stable for 10 cycles. Then wr_ready=1 -> 4 writes in order, st_ready=1 after first pop.
- Full buffer, st_valid=1 and wr_ready=1 same cycle -> pop only, count 4->3. Push accepted the following cycle.
- Stores to 0x200: {0x11111111, mask 0x3} then {0x22222222, mask 0x6}; ld_addr=0x202 -> fwd_mask=0x7, fwd_data=0x00222211, fwd_hit=1. ld_addr=0x204 -> fwd_hit=0.
- 20 push/pop cycles with wr_ready toggling every cycle (wraps pointers) -> written sequence equals pushed sequence. Forwarding always picks youngest.
- Assert reset with 3 entries queued and wr_valid=1 -> wr_valid=0, count=0 immediately (async). No write after release.
